multdiv_alu_sequencer: RTL and testbench

Multi-cycle signed multiply/divide controller that time-shares the existing 32-bit ALU instead of instantiating its own adder. Accepts a one-cycle start pulse (ctrl_MULT or ctrl_DIV) and latches the operands. It then drives the ALU operand, opcode and shamt inputs for one add/subtract per cycle across 32 iterations, and returns a 32-bit result with an exception flag. Sits beside the ALU in the execute stage; the processor stalls until data_resultRDY.

---
 rtl/multdiv_alu_sequencer_if.sv | 40 ++++
 rtl/multdiv_alu_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_multdiv_alu_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_alu_sequencer_if.sv
// Execute-stage bundle between the processor, the shared ALU and the multiply/divide sequencer.
// MULTDIV_REMAINDER_EN adds the data_remainder signal.
interface multdiv_alu_sequencer_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        busy;
`ifdef MULTDIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  // Processor/ALU side
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
    input  data_result, data_exception, data_resultRDY, alu_opA, alu_opB,
           alu_opcode, alu_shamt, busy
`ifdef MULTDIV_REMAINDER_EN
    , input data_remainder
`endif
  );

  // Sequencer side
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
    output data_result, data_exception, data_resultRDY, alu_opA, alu_opB,
           alu_opcode, alu_shamt, busy
`ifdef MULTDIV_REMAINDER_EN
    , output data_remainder
`endif
  );
endinterface

// File: rtl/multdiv_alu_sequencer.sv
// Signed 32-bit multiply/divide sequencer that borrows the execute-stage ALU for one add/sub per cycle.
// Optional MULTDIV_REMAINDER_EN: signed remainder output, negated in an extra ALU cycle on DIV.
module multdiv_alu_sequencer #(
  parameter logic [31:0] DIVZERO_RESULT = 32'h0000_0000,
  parameter int unsigned ITERS          = 32
) (
  input logic                    clock,
  input logic                    reset,
  multdiv_alu_sequencer_if.slave bus
);
  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [4:0]  OP_ADD = 5'b00000;
  localparam logic [4:0]  OP_SUB = 5'b00001;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_REM, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, busy_q;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [4:0]       opc_q, opc_d;
`ifdef MULTDIV_REMAINDER_EN
  logic             sa_q, sa_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     rem_q, rem_d;
`endif

  logic [W-1:0] rs;
  logic [W-1:0] mul_b;
  logic         carry;
  logic         nb;
  logic [W-1:0] fix_res;
  logic         fix_exc;

  // Next-state, datapath and registered-ALU-input computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    dz_d     = dz_q;
    sign_d   = sign_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    exc_d    = exc_q;
    opa_d    = '0;
    opb_d    = '0;
    opc_d    = OP_ADD;
    rs       = {hi_q[W-2:0], lo_q[W-1]};
    mul_b    = lo_q[0] ? a_q : '0;
    carry    = 1'b0;
    nb       = 1'b0;
    fix_res  = sign_q ? bus.alu_result : lo_q;
    fix_exc  = div_q ? (~sign_q & lo_q[W-1])
                     : ((hi_q != '0) | (lo_q[W-1] & (~sign_q | (lo_q[W-2:0] != '0))));
`ifdef MULTDIV_REMAINDER_EN
    sa_d     = sa_q;
    res_d    = res_q;
    rem_d    = rem_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.ctrl_MULT | bus.ctrl_DIV) begin
          state_d = S_LOAD;
          div_d   = ~bus.ctrl_MULT;
          a_d     = bus.data_operandA;
          b_d     = bus.data_operandB;
          sign_d  = bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
`ifdef MULTDIV_REMAINDER_EN
          sa_d    = bus.data_operandA[W-1];
`endif
        end
      end
      S_LOAD: begin
        a_d   = a_q[W-1] ? -a_q : a_q;
        b_d   = b_q[W-1] ? -b_q : b_q;
        cnt_d = '0;
        hi_d  = '0;
        lo_d  = div_q ? a_d : b_d;
        dz_d  = div_q & (b_q == '0);
        state_d = dz_d ? S_FIX : S_ITER;
      end
      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_q) begin
          // Restoring step: keep the ALU difference only when the shifted remainder covers |B|
          nb   = hi_q[W-1] | (rs[W-1] & ~b_q[W-1]) |
                 (~(rs[W-1] ^ b_q[W-1]) & ~bus.alu_result[W-1]);
          hi_d = nb ? bus.alu_result : rs;
          lo_d = {lo_q[W-2:0], nb};
        end else begin
          carry = (hi_q[W-1] & mul_b[W-1]) |
                  ((hi_q[W-1] | mul_b[W-1]) & ~bus.alu_result[W-1]);
          hi_d  = {carry, bus.alu_result[W-1:1]};
          lo_d  = {bus.alu_result[0], lo_q[W-1:1]};
        end
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (dz_q) begin
          result_d = DIVZERO_RESULT;
          exc_d    = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
          rem_d    = '0;
`endif
        end else begin
          result_d = fix_res;
          exc_d    = fix_exc;
`ifdef MULTDIV_REMAINDER_EN
          rem_d    = '0;
          if (div_q) begin
            res_d   = fix_res;
            state_d = S_REM;
          end
`endif
        end
      end
`ifdef MULTDIV_REMAINDER_EN
      S_REM: begin
        result_d = res_q;
        exc_d    = ~sign_q & lo_q[W-1];
        rem_d    = sa_q ? bus.alu_result : hi_q;
        state_d  = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ALU inputs are registered, so they are prepared from the upcoming state
    case (state_d)
      S_ITER: begin
        if (div_d) begin
          opa_d = {hi_d[W-2:0], lo_d[W-1]};
          opb_d = b_d;
          opc_d = OP_SUB;
        end else begin
          opa_d = hi_d;
          opb_d = lo_d[0] ? a_d : '0;
          opc_d = OP_ADD;
        end
      end
      S_FIX: begin
        if (!dz_d) begin
          opb_d = lo_d;
          opc_d = OP_SUB;
        end
      end
      S_REM: begin
        opb_d = hi_d;
        opc_d = OP_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
      sign_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= OP_ADD;
`ifdef MULTDIV_REMAINDER_EN
      sa_q     <= 1'b0;
      res_q    <= '0;
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      dz_q     <= dz_d;
      sign_q   <= sign_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
`ifdef MULTDIV_REMAINDER_EN
      sa_q     <= sa_d;
      res_q    <= res_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
  assign bus.alu_opA        = opa_q;
  assign bus.alu_opB        = opb_q;
  assign bus.alu_opcode     = opc_q;
  assign bus.alu_shamt      = 5'd0;
`ifdef MULTDIV_REMAINDER_EN
  assign bus.data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_multdiv_alu_sequencer.sv
// Scoreboard bench for multdiv_alu_sequencer with a behavioural ADD/SUB ALU on the shared port.
module tb_multdiv_alu_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;

`ifdef MULTDIV_REMAINDER_EN
  localparam int unsigned DIV_LAT = 35;
`else
  localparam int unsigned DIV_LAT = 34;
`endif

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int unsigned start;
    int unsigned lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  multdiv_alu_sequencer_if bus();

  multdiv_alu_sequencer #(.DIVZERO_RESULT(32'h0000_0000), .ITERS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign bus.alu_result = (bus.alu_opcode == 5'b00001) ? (bus.alu_opA - bus.alu_opB)
                                                       : (bus.alu_opA + bus.alu_opB);

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (op %0d): got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: pop the oldest expectation on every done strobe
  always @(negedge clock) begin
    if (bus.data_resultRDY === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdy: got strobe at edge %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result",    mon_e.id, bus.data_result, mon_e.res);
        check("exception", mon_e.id, 32'(bus.data_exception), 32'(mon_e.exc));
        check("latency",   mon_e.id, 32'(cyc - mon_e.start), 32'(mon_e.lat));
        check("busy_done", mon_e.id, 32'(bus.busy), 32'd1);
        check("alu_idle",  mon_e.id, bus.alu_opA | bus.alu_opB | 32'(bus.alu_opcode) | 32'(bus.alu_shamt), 32'd0);
`ifdef MULTDIV_REMAINDER_EN
        check("remainder", mon_e.id, bus.data_remainder, mon_e.rem);
`endif
      end
    end
  end

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input logic [31:0] erem,
                        input int unsigned lat, input int id, input int unsigned extra_div);
    int          d0;
    logic        busy_ok;
    int unsigned s;
    d0 = done_cnt;
    busy_ok = 1'b1;
    bus.ctrl_MULT = m;
    bus.ctrl_DIV = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    s = cyc + 1;
    sb.push_back('{er, ee, erem, s, lat, id});
    @(negedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = ~a;
    bus.data_operandB = a ^ b ^ 32'h5A5A_0001;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.ctrl_DIV = (extra_div != 0) && (cyc + 1 == s + extra_div);
      @(negedge clock); #1;
    end
    bus.ctrl_DIV = 1'b0;
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL timeout (op %0d): got no strobe in 60 cycles expected one", id);
    end
    check("busy_window", id, 32'(busy_ok), 32'd1);
    repeat (2) @(negedge clock);
    #1;
  endtask

  initial begin
    int          d0;
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_result", 0, bus.data_result, 32'd0);
    check("rst_exc",    0, 32'(bus.data_exception), 32'd0);
    check("rst_rdy",    0, 32'(bus.data_resultRDY), 32'd0);
    check("rst_busy",   0, 32'(bus.busy), 32'd0);
    check("rst_alu",    0, bus.alu_opA | bus.alu_opB | 32'(bus.alu_opcode), 32'd0);
    reset = 1'b0;
    @(negedge clock); #1;

    run_op(1, 0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, 32'd0,         34,      1, 0);
    run_op(1, 0, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1, 32'd0,         34,      2, 0);
    run_op(1, 0, 32'h8000_0000, 32'd1,         32'h8000_0000, 0, 32'd0,         34,      3, 0);
    run_op(1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25,        0, 32'd0,         34,      4, 0);
    run_op(0, 1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 0, 32'hFFFF_FFFE, DIV_LAT, 5, 0);
    run_op(0, 1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 32'd2,         DIV_LAT, 6, 0);
    run_op(0, 1, 32'd5,         32'd0,         32'd0,         1, 32'd0,         2,       7, 0);
    run_op(0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         0, 32'hFFFF_FFFF, DIV_LAT, 8, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 32'd0,         DIV_LAT, 9, 0);
    run_op(1, 1, 32'd6,         32'd3,         32'd18,        0, 32'd0,         34,     10, 10);

    // Abort a multiply with reset partway through
    d0 = done_cnt;
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'd7;
    bus.data_operandB = 32'd9;
    @(negedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    repeat (19) @(negedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock); #1;
    check("abort_busy",   11, 32'(bus.busy), 32'd0);
    check("abort_rdy",    11, 32'(bus.data_resultRDY), 32'd0);
    check("abort_result", 11, bus.data_result, 32'd0);
    check("abort_alu",    11, bus.alu_opA | bus.alu_opB | 32'(bus.alu_opcode), 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    #1;
    check("abort_no_rdy", 11, 32'(done_cnt - d0), 32'd0);

    run_op(1, 0, 32'd3, 32'd3, 32'd9, 0, 32'd0, 34, 12, 0);

    repeat (40) @(negedge clock);
    #1;
    check("strobe_count", 13, 32'(done_cnt), 32'd11);
    check("sb_drained",   13, 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
